// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: builds the 6-byte CMD frame with CRC7, drives
// spi_controller to transmit it, then polls single-byte reads for the R1 response.
module sd_cmd_sequencer #(
   parameter int  MEMORY_SIZE_IN_BYTES = 10,
   parameter int  POLL_LIMIT           = 8,
   localparam int ADDR_W               = $clog2(MEMORY_SIZE_IN_BYTES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [5:0]        cmd_index,
   input  logic [31:0]       cmd_arg,
   output logic              resp_valid,
   output logic [7:0]        resp_r1,
   output logic              resp_timeout,
   output logic              spi_start,
   output logic              spi_op,
   output logic [ADDR_W-1:0] spi_size,
   input  logic [ADDR_W-1:0] spi_address,
   output logic [7:0]        spi_rd_data,
   input  logic              spi_wr,
   input  logic [7:0]        spi_wr_data,
   input  logic              spi_done
);

   localparam int CNT_W = $clog2(POLL_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE, SEND_START, SEND_WAIT, POLL_START, POLL_WAIT, RESP
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        frame_q [6];
   logic [7:0]        frame_d [6];
   logic [7:0]        rx_q, rx_d;
   logic [7:0]        r1_q, r1_d;
   logic              to_q, to_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] size_q, size_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        arg_byte [4];
   logic [7:0]        poll_byte;
   logic [7:0]        hdr_byte;

   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = data[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_arg
         assign arg_byte[gi] = cmd_arg[31-8*gi -: 8];
      end
   endgenerate

   assign hdr_byte  = {2'b01, cmd_index};
   // A byte written in the same cycle as spi_done has not reached rx_q yet.
   assign poll_byte = spi_wr ? spi_wr_data : rx_q;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      rx_d    = spi_wr ? spi_wr_data : rx_q;
      r1_d    = r1_q;
      to_d    = to_q;
      op_d    = op_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               frame_d[0] = hdr_byte;
               for (int i = 0; i < 4; i++) frame_d[i+1] = arg_byte[i];
               frame_d[5] = {crc7({hdr_byte, cmd_arg}), 1'b1};
               op_d       = 1'b1;
               size_d     = ADDR_W'(5);
               state_d    = SEND_START;
            end
         end
         SEND_START: state_d = SEND_WAIT;
         SEND_WAIT: begin
            if (spi_done) begin
               cnt_d   = '0;
               op_d    = 1'b0;
               size_d  = '0;
               state_d = POLL_START;
            end
         end
         POLL_START: state_d = POLL_WAIT;
         POLL_WAIT: begin
            if (spi_done) begin
               if (!poll_byte[7]) begin
                  r1_d    = poll_byte;
                  to_d    = 1'b0;
                  state_d = RESP;
               end else if (cnt_q == CNT_W'(POLL_LIMIT - 1)) begin
                  r1_d    = 8'hFF;
                  to_d    = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = POLL_START;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         for (int i = 0; i < 6; i++) frame_q[i] <= 8'hFF;
         rx_q    <= 8'hFF;
         r1_q    <= 8'hFF;
         to_q    <= 1'b0;
         op_q    <= 1'b0;
         size_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < 6; i++) frame_q[i] <= frame_d[i];
         rx_q    <= rx_d;
         r1_q    <= r1_d;
         to_q    <= to_d;
         op_q    <= op_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      spi_rd_data = 8'hFF;
      for (int i = 0; i < 6; i++) begin
         if (spi_address == ADDR_W'(i)) spi_rd_data = frame_q[i];
      end
   end

   assign cmd_ready    = (state_q == IDLE);
   assign spi_start    = (state_q == SEND_START) || (state_q == POLL_START);
   assign resp_valid   = (state_q == RESP);
   assign resp_r1      = r1_q;
   assign resp_timeout = to_q;
   assign spi_op       = op_q;
   assign spi_size     = size_q;

endmodule
